// File: rtl/dsp_data_mem_bank_pkg.sv
// Shared sizing and types for the DSP data-memory responder.
// The DSP_MEM_PARITY_EN macro, when defined, adds a parity bit to each array word in the top.
package dsp_data_mem_bank_pkg;

    localparam int SRAM_ADDR_LEN    = 8;
    localparam int REG_WORD_LEN     = 16;
    localparam int SB_DEPTH_DEFAULT = 4;

    // Where the bank-2 load data of an accepted read comes from.
    typedef enum logic [1:0] {
        SRC_ARRAY  = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_SBUF   = 2'd2
    } rd_src_e;

endpackage

// File: rtl/dsp_store_buffer.sv
// Circular store buffer for posted bank-2 stores.
// Supports push at the tail, pop from the head, occupancy count and a
// youngest-first address lookup used for load forwarding.
module dsp_store_buffer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              hit_o,
    output logic [DATA_W-1:0] hit_data_o
);

    logic [ADDR_W-1:0] entry_addr_q [DEPTH];
    logic [DATA_W-1:0] entry_data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok;
    logic              pop_ok;
    logic [PTR_W-1:0]  look_idx;

    // Occupancy flags and guarded push/pop strobes.
    always_comb begin
        full_o      = (count_q == CNT_W'(DEPTH));
        empty_o     = (count_q == '0);
        push_ok     = push_i && !full_o;
        pop_ok      = pop_i && !empty_o;
        count_o     = count_q;
        head_addr_o = entry_addr_q[rd_ptr_q];
        head_data_o = entry_data_q[rd_ptr_q];
    end

    // Youngest match wins: walk from oldest age to youngest so the last hit overrides.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        look_idx   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            look_idx = wr_ptr_q - PTR_W'(k + 1);
            if ((CNT_W'(k) < count_q) && (entry_addr_q[look_idx] == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = entry_data_q[look_idx];
            end
        end
    end

    // Entry storage is written at the tail on push; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            entry_addr_q[wr_ptr_q] <= push_addr_i;
            entry_data_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dsp_data_mem_bank.sv
// DSP data-memory responder: bank 1 / bank 2 loads, bank 2 posted stores.
// Stores go through a store buffer and drain to bank 2 when the array port is free.
// Optional DSP_MEM_PARITY_EN: arrays carry an even-parity bit and parity_err_o flags bad array reads.
module dsp_data_mem_bank
    import dsp_data_mem_bank_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_LEN,
    parameter int DATA_W   = REG_WORD_LEN,
    parameter int SB_DEPTH = SB_DEPTH_DEFAULT,
    localparam int CNT_W   = $clog2(SB_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] read_addr_1_i,
    input  logic [ADDR_W-1:0] read_addr_2_i,
    input  logic              write_en_i,
    input  logic [ADDR_W-1:0] write_addr_2_i,
    input  logic [DATA_W-1:0] write_data_i,
    output logic [DATA_W-1:0] read_data_1_o,
    output logic [DATA_W-1:0] read_data_2_o,
    output logic              rd_valid_o,
    output logic              mem_stall_o,
    output logic [CNT_W-1:0]  sb_count_o
`ifdef DSP_MEM_PARITY_EN
    ,
    output logic              parity_err_o
`endif
);

`ifdef DSP_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam int MEM_DEPTH = 2 ** ADDR_W;

    logic [MEM_W-1:0]  bank1_mem [MEM_DEPTH];
    logic [MEM_W-1:0]  bank2_mem [MEM_DEPTH];

    logic [DATA_W-1:0] read_data_1_q;
    logic [DATA_W-1:0] read_data_2_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd1_data_d;
    logic [DATA_W-1:0] rd2_data_d;

    logic              sb_full;
    logic              sb_empty;
    logic [CNT_W-1:0]  sb_count;
    logic [ADDR_W-1:0] sb_head_addr;
    logic [DATA_W-1:0] sb_head_data;
    logic              sb_hit;
    logic [DATA_W-1:0] sb_hit_data;

    logic              stall;
    logic              rd_acc;
    logic              wr_acc;
    logic              drain;
    logic [MEM_W-1:0]  bank1_word;
    logic [MEM_W-1:0]  bank2_word;
    logic [MEM_W-1:0]  head_word;
    rd_src_e           rd2_src;

    dsp_store_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (SB_DEPTH)
    ) u_store_buffer (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (wr_acc),
        .push_addr_i   (write_addr_2_i),
        .push_data_i   (write_data_i),
        .pop_i         (drain),
        .lookup_addr_i (read_addr_2_i),
        .head_addr_o   (sb_head_addr),
        .head_data_o   (sb_head_data),
        .count_o       (sb_count),
        .full_o        (sb_full),
        .empty_o       (sb_empty),
        .hit_o         (sb_hit),
        .hit_data_o    (sb_hit_data)
    );

    // Request acceptance and drain scheduling; a full buffer blocks requests but still drains.
    always_comb begin
        stall  = sb_full && (rd_en_i || write_en_i);
        rd_acc = rd_en_i && !stall;
        wr_acc = write_en_i && !stall;
        drain  = !rst_i && !sb_empty && (!rd_en_i || sb_full);
    end

    // Array read ports and the word written on drain.
    always_comb begin
        bank1_word = bank1_mem[read_addr_1_i];
        bank2_word = bank2_mem[read_addr_2_i];
`ifdef DSP_MEM_PARITY_EN
        head_word  = {^sb_head_data, sb_head_data};
`else
        head_word  = sb_head_data;
`endif
    end

    // Bank-2 forwarding source: same-cycle store, then youngest buffered store, then array.
    always_comb begin
        rd2_src = SRC_ARRAY;
        if (wr_acc && (write_addr_2_i == read_addr_2_i)) begin
            rd2_src = SRC_BYPASS;
        end else if (sb_hit) begin
            rd2_src = SRC_SBUF;
        end
    end

    // Next load data for both banks.
    always_comb begin
        rd1_data_d = bank1_word[DATA_W-1:0];
        case (rd2_src)
            SRC_BYPASS: rd2_data_d = write_data_i;
            SRC_SBUF:   rd2_data_d = sb_hit_data;
            default:    rd2_data_d = bank2_word[DATA_W-1:0];
        endcase
    end

    // Load result registers; data holds when no read is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            read_data_1_q <= '0;
            read_data_2_q <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                read_data_1_q <= rd1_data_d;
                read_data_2_q <= rd2_data_d;
            end
        end
    end

    // Bank 2 single write port, fed only by the store-buffer drain.
    always_ff @(posedge clk_i) begin
        if (drain) begin
            bank2_mem[sb_head_addr] <= head_word;
        end
    end

`ifdef DSP_MEM_PARITY_EN
    logic parity_err_q;
    logic par_bad_d;

    // Only data that actually came from an array is parity checked.
    always_comb begin
        par_bad_d = rd_acc && ((^bank1_word) || ((rd2_src == SRC_ARRAY) && (^bank2_word)));
    end

    // Sticky parity error flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            parity_err_q <= 1'b0;
        end else if (par_bad_d) begin
            parity_err_q <= 1'b1;
        end
    end

    assign parity_err_o = parity_err_q;
`endif

    assign read_data_1_o = read_data_1_q;
    assign read_data_2_o = read_data_2_q;
    assign rd_valid_o    = rd_valid_q;
    assign mem_stall_o   = stall;
    assign sb_count_o    = sb_count;

endmodule
